// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU op codes, forward selects, EX/MEM register layout.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Everything memory_cycle consumes from the EX stage.
  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            result_src;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
  } ex_mem_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU. Add, sub and slt share one adder so the path
// operand -> result -> Zero stays a single carry chain plus a compare.
module alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  logic            sub_en;
  logic [XLEN-1:0] b_op;
  logic [XLEN-1:0] sum;
  logic            lt_signed;

  // Shared adder: subtraction (also used by slt) is A + ~B + 1.
  always_comb begin
    sub_en    = (ALUControl == ALU_SUB) || (ALUControl == ALU_SLT);
    b_op      = sub_en ? ~B : B;
    sum       = A + b_op + {{(XLEN-1){1'b0}}, sub_en};
    // Signs differ: A is less iff A is negative; otherwise the difference sign decides.
    lt_signed = (A[XLEN-1] ^ B[XLEN-1]) ? A[XLEN-1] : sum[XLEN-1];
  end

  // Result select; unused op codes produce 0.
  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = sum;
      ALU_SUB: Result = sum;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, lt_signed};
      default: Result = '0;
    endcase
    Zero = (Result == '0);
  end

endmodule

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, beq resolution, branch target and the
// EX/MEM pipeline register. Branch redirect is combinational back to fetch.
// There is no handshake: the EX/MEM register loads on every clock edge, and
// FlushE turns the captured instruction into a bubble.
module execute_cycle
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [REGW-1:0] RD_E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic            FlushE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [REGW-1:0] RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] ALU_ResultM,
  output logic [XLEN-1:0] WriteDataM
);

  ex_mem_t         ex_mem_q, ex_mem_d;
  logic [XLEN-1:0] src_a, fwd_b, src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // Forward muxes; select 11 falls back to the register file value.
  always_comb begin
    case (ForwardA_E)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ex_mem_q.alu_result;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ex_mem_q.alu_result;
      default: fwd_b = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  end

  alu u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (alu_zero)
  );

  // Branch resolution; a flushed instruction never redirects fetch.
  always_comb begin
    PCSrcE    = BranchE & alu_zero & ~FlushE;
    PCTargetE = PCE + Imm_Ext_E;
  end

  // Next EX/MEM contents; a flush clears the controls that have side effects.
  always_comb begin
    ex_mem_d.reg_write  = RegWriteE;
    ex_mem_d.mem_write  = MemWriteE;
    ex_mem_d.result_src = ResultSrcE;
    ex_mem_d.rd         = RD_E;
    ex_mem_d.pc_plus4   = PCPlus4E;
    ex_mem_d.alu_result = alu_result;
    ex_mem_d.write_data = fwd_b;
    if (FlushE) begin
      ex_mem_d.reg_write  = 1'b0;
      ex_mem_d.mem_write  = 1'b0;
      ex_mem_d.result_src = 1'b0;
      ex_mem_d.rd         = '0;
    end
  end

  // EX/MEM pipeline register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_mem_q <= '0;
    else     ex_mem_q <= ex_mem_d;
  end

  // Drive the M-stage outputs from the register.
  always_comb begin
    RegWriteM   = ex_mem_q.reg_write;
    MemWriteM   = ex_mem_q.mem_write;
    ResultSrcM  = ex_mem_q.result_src;
    RD_M        = ex_mem_q.rd;
    PCPlus4M    = ex_mem_q.pc_plus4;
    ALU_ResultM = ex_mem_q.alu_result;
    WriteDataM  = ex_mem_q.write_data;
  end

endmodule
